// File: rtl/sf_mem_ctrl.sv
// FIFO controller for an external synchronous dual-port memory with one-cycle read latency.
// Supports any depth >= 2, occupancy/threshold flags, sticky error flags, flush and optional FWFT.
module sf_mem_ctrl #(
   parameter int Width   = 32,
   parameter int Depth   = 16,
   parameter int AfLevel = Depth - 1,
   parameter int AeLevel = 1,
   parameter int Fwft    = 0,
   localparam int Aw     = ($clog2(Depth) > 1) ? $clog2(Depth) : 1,
   localparam int Cw     = $clog2(Depth + 1)
) (
   input  logic             fCLK,
   input  logic             fRSTn,
   input  logic             fCLR,
   input  logic             fPUSH,
   input  logic             fPOP,
   input  logic [Width-1:0] fD,
   output logic [Width-1:0] fQ,
   output logic             fVALID,
   output logic             fEMPTY,
   output logic             fFULL,
   output logic             fAEMPTY,
   output logic             fAFULL,
   output logic [Cw-1:0]    fCOUNT,
   output logic             fOVF,
   output logic             fUDF,
   output logic             we_o,
   output logic [Aw-1:0]    waddr_o,
   output logic [Width-1:0] wdata_o,
   output logic             re_o,
   output logic [Aw-1:0]    raddr_o,
   input  logic [Width-1:0] rdata_i
);

   logic [Aw-1:0] r_wptr, r_rptr;
   logic [Cw-1:0] r_count, r_mcount;
   logic          r_valid, r_ovf, r_udf;

   logic w_full, w_push_acc, w_pop_std, w_pop_fwft, w_fetch;
   logic w_pop_acc, w_rd, w_ovf_set, w_udf_set;

   function automatic logic [Aw-1:0] f_inc(input logic [Aw-1:0] p);
      return (p == Aw'(Depth - 1)) ? '0 : p + Aw'(1);
   endfunction

   assign w_full     = (r_count == Cw'(Depth));
   assign w_push_acc = fPUSH & ~w_full & ~fCLR;
   assign w_pop_std  = fPOP & (r_count != '0) & ~fCLR;
   assign w_pop_fwft = fPOP & r_valid & ~fCLR;
   // FWFT prefetches the next word whenever the output register is free or being consumed
   assign w_fetch    = (r_mcount != '0) & (~r_valid | w_pop_fwft) & ~fCLR;
   assign w_pop_acc  = (Fwft != 0) ? w_pop_fwft : w_pop_std;
   assign w_rd       = (Fwft != 0) ? w_fetch : w_pop_std;
   assign w_ovf_set  = fPUSH & w_full & ~fCLR;
   assign w_udf_set  = fPOP & ~fCLR & ((Fwft != 0) ? ~r_valid : (r_count == '0));

   always_ff @(posedge fCLK or negedge fRSTn) begin
      if (!fRSTn) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_mcount <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else if (fCLR) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_mcount <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_push_acc) r_wptr <= f_inc(r_wptr);
         if (w_rd)       r_rptr <= f_inc(r_rptr);
         case ({w_push_acc, w_pop_acc})
            2'b10:   r_count <= r_count + Cw'(1);
            2'b01:   r_count <= r_count - Cw'(1);
            default: r_count <= r_count;
         endcase
         case ({w_push_acc, w_rd})
            2'b10:   r_mcount <= r_mcount + Cw'(1);
            2'b01:   r_mcount <= r_mcount - Cw'(1);
            default: r_mcount <= r_mcount;
         endcase
         if (Fwft != 0) r_valid <= w_fetch | (r_valid & ~w_pop_fwft);
         else           r_valid <= w_pop_std;
         if (w_ovf_set) r_ovf <= 1'b1;
         if (w_udf_set) r_udf <= 1'b1;
      end
   end

   assign we_o    = w_push_acc;
   assign waddr_o = r_wptr;
   assign wdata_o = fD;
   assign re_o    = w_rd;
   assign raddr_o = r_rptr;

   assign fQ      = rdata_i;
   assign fVALID  = r_valid;
   assign fCOUNT  = r_count;
   assign fFULL   = w_full;
   assign fEMPTY  = (Fwft != 0) ? ~r_valid : (r_count == '0);
   assign fAEMPTY = (r_count <= Cw'(AeLevel));
   assign fAFULL  = (r_count >= Cw'(AfLevel));
   assign fOVF    = r_ovf;
   assign fUDF    = r_udf;

`ifdef SIM_LOG
   always @(posedge fCLK) begin
      if (fRSTn && w_ovf_set) $display("%m: push rejected (full) at %0t", $time);
      if (fRSTn && w_udf_set) $display("%m: pop rejected (empty) at %0t", $time);
   end
`endif

endmodule

// File: doc/sf_mem_ctrl.md
# sf_mem_ctrl

Parametrised FIFO control block that drives an external synchronous dual-port memory with one-cycle read latency. It is the next-generation FIFO front end and adds several features: arbitrary (non-power-of-2) depth, occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow flags, synchronous flush, and a selectable first-word-fall-through (FWFT) mode. It sits between a FIFO user and the memory macro, so the memory itself stays generic.

## Interface
- Width, 32, data width in bits
- Depth, 16, number of memory entries; any value ≥ 2
- AfLevel, Depth-1, fAFULL asserts when count ≥ AfLevel (1..Depth)
- AeLevel, 1, fAEMPTY asserts when count ≤ AeLevel (0..Depth-1)
- Fwft, 0, 0 = standard read mode, 1 = first-word-fall-through
- Aw (local), max(1,$clog2(Depth)); Cw (local), $clog2(Depth+1)

Ports:
- fCLK  in  1  clock
- fRSTn  in  1  reset: fRSTn, asynchronous, active-low; clock fCLK
- fCLR  in  1  synchronous flush
- fPUSH  in  1  write request
- fPOP  in  1  read request (standard) / consume head (FWFT)
- fD  in  Width  write data
- fQ  out  Width  read data (= rdata_i)
- fVALID  out  1  fQ valid
- fEMPTY, fFULL, fAEMPTY, fAFULL  out  1 each  status flags
- fCOUNT  out  Cw  accepted pushes minus accepted pops
- fOVF, fUDF  out  1 each  sticky rejected-push / rejected-pop flags
- we_o, waddr_o[Aw], wdata_o[Width]  out  memory write port
- re_o, raddr_o[Aw]  out  memory read port
- rdata_i  in  Width  memory read data, valid the cycle after re_o; must hold its value while re_o is low

## Operation
- Push is accepted when fPUSH & ~fFULL & ~fCLR. Accepted push: we_o=1, waddr_o=wptr, wdata_o=fD, and wptr advances.
- Rejected push (fPUSH & fFULL) sets fOVF. A push while full is rejected even if fPOP is high in the same cycle.
- Pointers wrap from Depth-1 to 0. No modulo-2^Aw wrap for non-power-of-2 Depth.
- count is the full item count (memory plus any head read out). fFULL = (count == Depth). fAFULL = (count ≥ AfLevel). fAEMPTY = (count ≤ AeLevel).
- Simultaneous accepted push and pop: count unchanged, and both pointers advance.
- **Standard mode (Fwft=0):**
  - Pop is accepted when fPOP & (count ≠ 0) & ~fCLR. Accepted pop: re_o=1, raddr_o=rptr, rptr advances, count decrements.
  - fVALID is high the next cycle only; fQ = rdata_i in that cycle.
  - fPOP while count = 0 is rejected and sets fUDF, even if fPUSH is high in the same cycle.
  - fEMPTY = (count == 0).
- **FWFT mode (Fwft=1):**
  - Internal mcount = items in memory not yet read out.
  - Fetch when mcount ≠ 0 & (~fVALID | popacc) & ~fCLR: re_o=1, rptr advances, mcount decrements. fVALID is set the next cycle.
  - popacc = fPOP & fVALID & ~fCLR. popacc decrements count; fVALID clears the next cycle unless a fetch occurred.
  - fPOP while ~fVALID sets fUDF. fEMPTY = ~fVALID.
- **fCLR:**
  - Next cycle: wptr, rptr, count, mcount and fVALID = 0; fOVF and fUDF cleared.
  - In the fCLR cycle, we_o and re_o are forced to 0 and push/pop are ignored (no flag sets).
- **Reset values:**
  - Pointers, count, mcount, fVALID, fFULL, fOVF, fUDF, we_o and re_o = 0.
  - fEMPTY = 1. fAEMPTY = 1. fAFULL = 0.
- Under `SIM_LOG`, rejected push and rejected pop are displayed.

## Timing
- Memory port outputs (we_o, waddr_o, wdata_o, re_o, raddr_o) are combinational from the registered pointers/count and the current inputs. All flags are derived from registers, with no combinational path from fPUSH/fPOP to the flags.
- Standard mode: pop at cycle t → fVALID and fQ in cycle t+1. Sustained 1 pop/cycle.
- FWFT mode, push into an empty FIFO at t: mcount=1 at t+1, re_o at t+1, fVALID at t+2. Latency is 2 cycles.
- FWFT steady state: popacc every cycle with mcount ≠ 0 keeps fVALID high, with a new fQ each cycle.
- Flags and count update on the clock edge after the accepted operation.
- Asynchronous reset mid-operation discards all contents immediately. fVALID drops without waiting for a clock edge.

## Test plan
Default parameters for all scenarios: Width=8, Depth=5, AfLevel=4, AeLevel=1.

- **Standard mode, fill:** 5 pushes 0x11..0x55 → fCOUNT 1..5, fAEMPTY high until count=2, fAFULL at count=4, fFULL at count=5. A 6th push → we_o=0 and fOVF=1.
- **Standard mode, drain with wrap:** 3 pops, 3 pushes 0xA1..0xA3, then 5 pops → fQ sequence 0x44, 0x55, 0xA1, 0xA2, 0xA3 each one cycle after the pop. waddr_o wraps 4→0.
- **Simultaneous push/pop:** at count=0 → push accepted, pop rejected, fUDF=1. At count=5 → pop accepted, push rejected, fOVF=1. At count=2 → count stays 2.
- **FWFT mode:** push 0x0A at t → fVALID=1, fQ=0x0A at t+2. With 3 queued items, continuous fPOP → 3 consecutive fVALID cycles with the items in order, then fEMPTY=1.
- **fCLR:** with count=3 and fOVF=1, assert fCLR together with fPUSH → next cycle fCOUNT=0, fEMPTY=1, fOVF=0, and we_o stayed 0 in the fCLR cycle.
- **Reset mid-stream:** deassert fRSTn during a pop burst → all outputs take their reset values immediately, and after release the first push/pop round-trips correctly.
